uart_tx_buf: RTL and testbench

- 8N1 UART transmitter with a one-entry holding buffer and a valid/ready byte interface; the transmit-side counterpart of the team's UART receiver.
- Serialises bytes LSB-first onto o_tx.
- The buffer lets a producer queue the next byte while the current frame shifts out, so frames go back-to-back with no idle gap.
- Sits between the host-side byte producer and the board TX pin.

---
 rtl/uart_tx_buf.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter with a one-entry holding buffer, LSB-first onto o_tx.
// Latency: byte accepted at edge N drives the start bit from edge N+1; frame = (9+STOP_BITS)*BAUD cycles.
// Backpressure: o_ready (registered) is low while the holding buffer is full; i_data is ignored then.
module uart_tx_buf #(
  parameter int BAUD      = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_tick;
  logic        accept;
  logic        reload;

  assign bit_tick = (cnt_q == BAUD_LAST);
  // ready_q is low whenever hold is full, so accept and reload are mutually exclusive
  assign accept   = i_valid && ready_q;

  assign o_ready = ready_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

  // Next-state: buffer capture, frame sequencing, and outputs precomputed from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    reload      = 1'b0;

    if (accept) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hold_full_q) reload = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            // A queued byte starts its frame straight out of the stop period
            if (hold_full_q) reload = 1'b1;
            else             state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = START;
      cnt_d       = '0;
      bit_idx_d   = '0;
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (cnt_d == BAUD_LAST) && (bit_idx_d == STOP_LAST);
    ready_d = !hold_full_d;
  end

  // State and output registers; async reset returns the line to idle-high at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: two instances (1 and 2 stop bits, BAUD=4) checked every cycle
// against a frame-schedule model: each accepted byte gets a start time of
// max(accept+1, end of previous frame) and the line level follows from that.
module tb_uart_tx_buf;
  localparam int B  = 4;
  localparam int NF = 256;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
  logic       rdy0, tx0, busy0, done0;
  logic       rdy1, tx1, busy1, done1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         nfr   [2];
  int         acc_e [2][NF];
  int         st_e  [2][NF];
  logic [7:0] byt   [2][NF];

  always #5 clk = ~clk;

  uart_tx_buf #(.BAUD(B), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .i_data(dat0), .i_valid(vld0),
    .o_ready(rdy0), .o_tx(tx0), .o_busy(busy0), .o_done(done0)
  );

  uart_tx_buf #(.BAUD(B), .STOP_BITS(2)) dut1 (
    .clk(clk), .rstn(rstn), .i_data(dat1), .i_valid(vld1),
    .o_ready(rdy1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int flen(input int u);
    return (u == 0) ? 10 * B : 11 * B;
  endfunction

  function automatic logic m_tx(input int u, input int t);
    logic r;
    int   ph;
    r = 1'b1;
    for (int k = 0; k < nfr[u]; k++) begin
      if (t >= st_e[u][k] && t < st_e[u][k] + flen(u)) begin
        ph = (t - st_e[u][k]) / B;
        if (ph == 0)      r = 1'b0;
        else if (ph <= 8) r = byt[u][k][ph-1];
      end
    end
    return r;
  endfunction

  function automatic logic m_busy(input int u, input int t);
    logic r;
    r = 1'b0;
    for (int k = 0; k < nfr[u]; k++)
      if (t >= st_e[u][k] && t < st_e[u][k] + flen(u)) r = 1'b1;
    return r;
  endfunction

  function automatic logic m_done(input int u, input int t);
    logic r;
    r = 1'b0;
    for (int k = 0; k < nfr[u]; k++)
      if (t == st_e[u][k] + flen(u) - 1) r = 1'b1;
    return r;
  endfunction

  function automatic logic m_ready(input int u, input int t);
    logic r;
    r = 1'b1;
    for (int k = 0; k < nfr[u]; k++)
      if (t >= acc_e[u][k] && t < st_e[u][k]) r = 1'b0;
    return r;
  endfunction

  task automatic record(input int u, input logic [7:0] d);
    int s;
    s = cyc + 1;
    if (nfr[u] > 0 && st_e[u][nfr[u]-1] + flen(u) > s) s = st_e[u][nfr[u]-1] + flen(u);
    if (nfr[u] < NF) begin
      acc_e[u][nfr[u]] = cyc;
      st_e[u][nfr[u]]  = s;
      byt[u][nfr[u]]   = d;
      nfr[u]++;
    end
  endtask

  task automatic check_all();
    chk("u0_tx",    tx0,   m_tx(0, cyc));
    chk("u0_busy",  busy0, m_busy(0, cyc));
    chk("u0_done",  done0, m_done(0, cyc));
    chk("u0_ready", rdy0,  m_ready(0, cyc));
    chk("u1_tx",    tx1,   m_tx(1, cyc));
    chk("u1_busy",  busy1, m_busy(1, cyc));
    chk("u1_done",  done1, m_done(1, cyc));
    chk("u1_ready", rdy1,  m_ready(1, cyc));
  endtask

  // One clock: check at the falling edge, drive inputs, then log handshakes at the rising edge
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    logic r0, r1;
    @(negedge clk);
    check_all();
    vld0 = v0; dat0 = d0;
    vld1 = v1; dat1 = d1;
    r0 = m_ready(0, cyc);
    r1 = m_ready(1, cyc);
    @(posedge clk);
    cyc++;
    if (rstn) begin
      if (v0 && r0) record(0, d0);
      if (v1 && r1) record(1, d1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Hold i_valid on unit 0 until the byte is taken, with a bounded wait
  task automatic send0(input logic [7:0] b);
    int n0;
    int guard;
    n0    = nfr[0];
    guard = 0;
    while (nfr[0] == n0 && guard < 200) begin
      step(1'b1, b, 1'b0, 8'h00);
      guard++;
    end
    chk("send0_accept", 32'(nfr[0] != n0), 32'd1);
  endtask

  initial begin
    int target;
    int guard;
    nfr[0] = 0;
    nfr[1] = 0;

    // Reset held with i_valid asserted: outputs stay idle, nothing is taken
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b1, 8'($urandom));
    #2 rstn = 1'b1;
    idle(4);

    // Single frames: 0x55 on 1-stop unit, 0x00 on 2-stop unit
    step(1'b1, 8'h55, 1'b1, 8'h00);
    idle(60);

    // Back-to-back frames with i_valid held
    send0(8'hA3);
    send0(8'h0F);
    idle(90);

    // Backpressure: 0xFF held while the buffer is full
    send0(8'h11);
    send0(8'h22);
    send0(8'hFF);
    idle(100);

    // Random traffic on both units
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 3) == 0), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 8'($urandom));
    idle(100);

    // Reset in the middle of data bit 3
    send0(8'h3C);
    target = st_e[0][nfr[0]-1] + 4 * B + 1;
    guard  = 0;
    while (cyc < target && guard < 300) begin
      idle(1);
      guard++;
    end
    @(negedge clk);
    check_all();
    chk("pre_rst_busy", busy0, 32'd1);
    rstn   = 1'b0;
    nfr[0] = 0;
    nfr[1] = 0;
    #1;
    chk("rst_tx",    tx0,   32'd1);
    chk("rst_ready", rdy0,  32'd1);
    chk("rst_busy",  busy0, 32'd0);
    chk("rst_done",  done0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1, 8'($urandom));
    #2 rstn = 1'b1;
    idle(2);
    send0(8'h81);
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
